// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive/transmit blocks.
//   PAR_*         : encodings of the PARITY parameter (none / odd / even)
//   BAUD_CNT_W    : width of the per-bit cycle counter (covers CLK_DIV up to 65535)
//   uart_state_e  : frame FSM state encoding
//   majority3()   : 2-of-3 vote used to resolve a bit from three samples
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;

    localparam int BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler -- line synchroniser plus mid-bit 3-sample majority vote.
//   sclk     : clock
//   s_rst    : synchronous active-high reset (synchroniser flops reset to idle-high)
//   rx       : raw asynchronous serial line
//   baud_cnt : position inside the current bit, 0..CLK_DIV-1
//   rx_sync  : synchronised line (third flop)
//   bit_val  : majority of samples at M-1, M and the live synchronised line;
//              meaningful in the cycle where baud_cnt == M+1 (M = CLK_DIV/2)
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic                  sclk,
    input  logic                  s_rst,
    input  logic                  rx,
    input  logic [BAUD_CNT_W-1:0] baud_cnt,
    output logic                  rx_sync,
    output logic                  bit_val
);

    localparam logic [BAUD_CNT_W-1:0] SAMP_A = BAUD_CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BAUD_CNT_W-1:0] SAMP_B = BAUD_CNT_W'(CLK_DIV / 2);

    logic [2:0] sync_q;
    logic       samp_a;
    logic       samp_b;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            sync_q <= 3'b111;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync_q <= {sync_q[1:0], rx};
            if (baud_cnt == SAMP_A) samp_a <= sync_q[2];
            if (baud_cnt == SAMP_B) samp_b <= sync_q[2];
        end
    end

    assign rx_sync = sync_q[2];
    // third sample is the live line at M+1, so the vote resolves in that cycle
    assign bit_val = majority3(samp_a, samp_b, rx_sync);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parameterised UART receiver (start, DATA_BITS, optional
// parity, STOP_BITS), bit decisions by 3-sample majority near mid-bit.
//   sclk       : clock
//   s_rst      : synchronous active-high reset
//   rs232_rx   : asynchronous serial input, idle high
//   rx_data    : last received word, bit 0 = first bit on the line; held between frames
//   po_flag    : one-cycle pulse when a frame completes
//   parity_err : parity mismatch, only meaningful (and only nonzero) with po_flag
//   frame_err  : a stop bit sampled low, only meaningful (and only nonzero) with po_flag
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 sclk,
    input  logic                 s_rst,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam logic [BAUD_CNT_W-1:0] CNT_LAST  = BAUD_CNT_W'(CLK_DIV - 1);
    localparam logic [BAUD_CNT_W-1:0] CNT_DEC   = BAUD_CNT_W'(CLK_DIV / 2 + 1);
    localparam logic [3:0]            DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]            STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [3:0]            bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_sync, rx_prev, bit_val;
    logic                  perr_q, ferr_q;
    logic                  at_dec, at_end, fall, par_ref;
    logic                  shift_en, par_chk, stop_chk, done, idx_clr, idx_inc;

    uart_bit_sampler #(.CLK_DIV(CLK_DIV)) u_sampler (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .rx       (rs232_rx),
        .baud_cnt (baud_cnt),
        .rx_sync  (rx_sync),
        .bit_val  (bit_val)
    );

    assign at_dec  = (baud_cnt == CNT_DEC);
    assign at_end  = (baud_cnt == CNT_LAST);
    assign fall    = rx_prev & ~rx_sync;
    assign par_ref = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge sclk) begin
        if (s_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        par_chk  = 1'b0;
        stop_chk = 1'b0;
        done     = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        case (state_q)
            ST_IDLE: if (fall) state_d = ST_START;
            ST_START: begin
                // start bit that votes high was a glitch
                if (at_dec && bit_val) state_d = ST_IDLE;
                else if (at_end) begin
                    state_d = ST_DATA;
                    idx_clr = 1'b1;
                end
            end
            ST_DATA: begin
                shift_en = at_dec;
                if (at_end) begin
                    if (bit_idx == DATA_LAST) begin
                        idx_clr = 1'b1;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                par_chk = at_dec;
                if (at_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                stop_chk = at_dec;
                // finish at the last stop bit's decision point so a start edge in
                // the rest of that bit is still seen in IDLE
                if (at_dec && bit_idx == STOP_LAST) begin
                    done    = 1'b1;
                    state_d = (ferr_q | ~bit_val) ? ST_WAIT_IDLE : ST_IDLE;
                end else if (at_end) begin
                    idx_inc = 1'b1;
                end
            end
            ST_WAIT_IDLE: if (rx_sync) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            baud_cnt   <= '0;
            rx_prev    <= 1'b1;
            bit_idx    <= '0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data    <= '0;
            po_flag    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_prev <= rx_sync;

            if (state_q == ST_IDLE || state_q == ST_WAIT_IDLE ||
                state_d == ST_IDLE || state_d == ST_WAIT_IDLE || at_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 1'b1;

            if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};

            if (state_q == ST_IDLE) begin
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (par_chk)              perr_q <= bit_val ^ par_ref;
            if (stop_chk && !bit_val) ferr_q <= 1'b1;

            po_flag    <= done;
            parity_err <= done & perr_q;
            frame_err  <= done & (ferr_q | ~bit_val);
            if (done) rx_data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
    localparam int CD = 16;

    // three receivers: 8N1, 8E1, 7O2, each on its own serial line
    int db [3] = '{8, 8, 7};
    int pm [3] = '{0, 2, 1};
    int sb [3] = '{1, 1, 2};

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        longint     due;
    } exp_t;

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       rx_line [3];
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       po [3], pe [3], fe [3];
    logic [8:0] dat [3];

    exp_t   exp_q[$];
    longint cyc = 0;
    int     n_cmp = 0, n_mis = 0, viol = 0;
    int     n_po [3] = '{0, 0, 0};
    int     n_exp [3] = '{0, 0, 0};
    logic   po_prev [3] = '{1'b0, 1'b0, 1'b0};

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sclk(sclk), .s_rst(s_rst), .rs232_rx(rx_line[0]), .rx_data(d0),
        .po_flag(po[0]), .parity_err(pe[0]), .frame_err(fe[0]));
    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .sclk(sclk), .s_rst(s_rst), .rs232_rx(rx_line[1]), .rx_data(d1),
        .po_flag(po[1]), .parity_err(pe[1]), .frame_err(fe[1]));
    uart_rx_param #(.CLK_DIV(CD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .sclk(sclk), .s_rst(s_rst), .rs232_rx(rx_line[2]), .rx_data(d2),
        .po_flag(po[2]), .parity_err(pe[2]), .frame_err(fe[2]));

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {2'b00, d2};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // cycles from the edge that first clocks the start bit in to the po_flag edge
    function automatic longint lat(input int k);
        return 3 + (db[k] + ((pm[k] != 0) ? 1 : 0) + sb[k]) * CD + CD / 2 + 2;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // model: result of a frame follows from the bits put on the line
    task automatic send_frame(input int k, input logic [8:0] data, input bit par_flip,
                              input bit [1:0] stop_val);
        bit         bq[$];
        exp_t       e;
        logic [8:0] m;
        int         ones;
        bit         ideal, sent;
        m     = data & ((9'h1 << db[k]) - 9'h1);
        ones  = $countones(m);
        ideal = (pm[k] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        sent  = ideal ^ par_flip;
        bq.push_back(1'b0);
        for (int i = 0; i < db[k]; i++) bq.push_back(m[i]);
        if (pm[k] != 0) bq.push_back(sent);
        for (int i = 0; i < sb[k]; i++) bq.push_back(stop_val[i]);
        e.inst = k;
        e.data = m;
        e.perr = (pm[k] != 0) && (sent != ideal);
        e.ferr = (sb[k] == 2) ? !(stop_val[0] && stop_val[1]) : !stop_val[0];
        e.due  = cyc + 1 + lat(k);
        exp_q.push_back(e);
        n_exp[k]++;
        foreach (bq[i]) begin
            rx_line[k] = bq[i];
            idle(CD);
        end
    endtask

    task automatic drain(input string tag);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge sclk) begin
        if (!s_rst) begin
            for (int k = 0; k < 3; k++) begin
                if (!po[k] && (pe[k] || fe[k])) viol++;
                if (po[k] && po_prev[k]) viol++;
                po_prev[k] = po[k];
                if (po[k]) begin
                    int ei;
                    n_po[k]++;
                    ei = (exp_q.size() != 0) ? exp_q[0].inst : -1;
                    chk($sformatf("po_inst%0d", k), k, ei);
                    if (ei == k) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk($sformatf("data%0d", k), dat[k], e.data);
                        chk($sformatf("parity_err%0d", k), pe[k], e.perr);
                        chk($sformatf("frame_err%0d", k), fe[k], e.ferr);
                        chk($sformatf("latency%0d", k), cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) rx_line[k] = 1'b1;
        s_rst = 1'b1;
        idle(5);
        @(negedge sclk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_data%0d", k), dat[k], 0);
            chk($sformatf("rst_po%0d", k), po[k], 0);
            chk($sformatf("rst_flags%0d", k), {pe[k], fe[k]}, 0);
        end
        @(posedge sclk); #1;
        s_rst = 1'b0;
        idle(10);

        // 8N1 basic frame
        send_frame(0, 9'h0A5, 1'b0, 2'b11); idle(4); drain("drain_8n1_a5");

        // 8E1 with bad, then good parity
        send_frame(1, 9'h037, 1'b1, 2'b11); idle(4); drain("drain_8e1_bad");
        send_frame(1, 9'h037, 1'b0, 2'b11); idle(4); drain("drain_8e1_good");

        // 7O2 second stop low, line then held low (break): nothing more until high
        send_frame(2, 9'h041, 1'b0, 2'b01);
        idle(40);
        rx_line[2] = 1'b1;
        idle(20); drain("drain_7o2_break");
        send_frame(2, 9'h041, 1'b0, 2'b11); idle(4); drain("drain_7o2_after");

        // start glitch of 4 cycles on idle 8N1 line
        rx_line[0] = 1'b0; idle(4);
        rx_line[0] = 1'b1; idle(40);
        send_frame(0, 9'h05A, 1'b0, 2'b11); idle(4); drain("drain_glitch_5a");

        // back-to-back: second start follows the first stop bit directly
        send_frame(0, 9'h000, 1'b0, 2'b11);
        send_frame(0, 9'h0FF, 1'b0, 2'b11); idle(4); drain("drain_b2b");

        // reset during data bit 3 of 0x99
        rx_line[0] = 1'b0; idle(CD);
        rx_line[0] = 1'b1; idle(CD);
        rx_line[0] = 1'b0; idle(CD);
        rx_line[0] = 1'b0; idle(CD);
        rx_line[0] = 1'b1; idle(CD / 2);
        s_rst = 1'b1;
        idle(3);
        s_rst = 1'b0;
        idle(1);
        @(negedge sclk);
        chk("rstmid_data", dat[0], 0);
        chk("rstmid_po", po[0], 0);
        chk("rstmid_flags", {pe[0], fe[0]}, 0);
        @(posedge sclk); #1;
        idle(4 * CD);
        send_frame(0, 9'h012, 1'b0, 2'b11); idle(4); drain("drain_after_rst");

        // randomized frames across all three receivers
        for (int n = 0; n < 30; n++) begin
            int         k;
            logic [8:0] d;
            bit         flip;
            bit [1:0]   sv;
            k    = $urandom_range(0, 2);
            d    = 9'($urandom);
            flip = (pm[k] != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            sv   = 2'b11;
            if ($urandom_range(0, 4) == 0) sv = 2'($urandom_range(0, 2));
            send_frame(k, d, flip, sv);
            rx_line[k] = 1'b1;
            idle($urandom_range(2, 12));
            drain($sformatf("drain_rand%0d", n));
        end

        idle(20);
        chk("stray_or_long_flags", viol, 0);
        for (int k = 0; k < 3; k++) chk($sformatf("po_count%0d", k), n_po[k], n_exp[k]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning sclk cycles per bit; legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port sclk, input, 1 bit: the single clock.
REQ-006 SHALL have port s_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rs232_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: received word, bit 0 = first received bit.
REQ-009 SHALL have port po_flag, output, 1 bit: one-cycle pulse marking frame complete.
REQ-010 SHALL have port parity_err, output, 1 bit: parity mismatch, valid while po_flag = 1.
REQ-011 SHALL have port frame_err, output, 1 bit: a stop bit sampled low, valid while po_flag = 1.

Function
REQ-012 SHALL pass rs232_rx through a 3-flop synchroniser; all decisions SHALL use the synchronised line only.
REQ-013 SHALL detect a start condition in IDLE as a synchronised high-to-low transition.
REQ-014 SHALL run a bit counter baud_cnt over 0..CLK_DIV-1, cleared on the start condition and on every bit boundary.
REQ-015 SHALL take samples at baud_cnt = M-1, M and M+1, with M = CLK_DIV/2, and resolve each bit by 2-of-3 majority at M+1.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-017 START: if the majority result is 1, treat it as a glitch and return to IDLE with no po_flag; otherwise move to DATA at the bit boundary.
REQ-018 DATA: shift in DATA_BITS bits LSB first, then go to PARITY if PARITY != 0, else to STOP.
REQ-019 PARITY: compare the sampled bit with the XOR of the data bits (odd mode inverts the XOR); a mismatch latches parity_err.
REQ-020 STOP: sample STOP_BITS stop bits; any low sample latches frame_err.
REQ-021 At the M+1 decision of the last stop bit: update rx_data, pulse po_flag for exactly one cycle in the next cycle, and drive parity_err and frame_err alongside it.
REQ-022 The FSM SHALL leave STOP at that decision point, not at the bit end, so a start edge in the remaining half stop bit is accepted.
REQ-023 After the decision point, go to IDLE if frame_err = 0; if frame_err = 1 (break or held-low line), go to WAIT_IDLE and stay until the synchronised line is high for 1 cycle, with no false start.
REQ-024 rx_data SHALL hold its value between frames.
REQ-025 parity_err and frame_err SHALL be 0 whenever po_flag = 0.
REQ-026 Latency from the start-edge at the synchroniser input to po_flag SHALL be 3 + (1+DATA_BITS+P+STOP_BITS-1)*CLK_DIV + M + 2 cycles, where P = (PARITY != 0).
REQ-027 A falling edge in any state other than IDLE SHALL be ignored.

Reset
REQ-028 On s_rst = 1 at a sclk edge: FSM to IDLE, baud_cnt = 0, rx_data = 0, po_flag = 0, parity_err = 0, frame_err = 0, and synchroniser flops = 1.
REQ-029 A reset mid-frame SHALL abort the frame with no po_flag; reception SHALL resume from the next falling edge after reset release.

Structure
REQ-030 The shared package uart_pkg SHALL hold the PARITY encodings (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state encodings, for reuse by uart_tx_param.
REQ-031 Synchroniser plus 3-sample majority SHALL be the sub-module uart_bit_sampler, with inputs sclk, s_rst, rx, baud_cnt and outputs rx_sync, bit_val.
REQ-032 The bench SHALL override CLK_DIV = 16 for simulation.

Verification
REQ-033 8N1: send 0xA5 -> po_flag pulse once, rx_data = 0xA5, both error flags 0.
REQ-034 8E1: send 0x37 with the parity bit flipped -> po_flag, rx_data = 0x37, parity_err = 1; same frame with correct parity -> parity_err = 0.
REQ-035 7O2: send 0x41 with the second stop bit low -> frame_err = 1, po_flag = 1, then no new frame until the line returns high.
REQ-036 Glitch: a 4-cycle low pulse on an idle line -> no po_flag, FSM back in IDLE; a following 0x5A frame is received correctly.
REQ-037 Back-to-back 8N1 frames 0x00 then 0xFF, the second start 8 cycles after the first stop midpoint -> two po_flag pulses with correct data.
REQ-038 Assert s_rst during DATA bit 3 of frame 0x99 -> no po_flag, all outputs 0; a next frame 0x12 is received as 0x12.
